// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, address-width helper and types for the scoreboarded register file
package regfile_pkg;

  localparam int N_DEF = 32;
  localparam int L_DEF = 32;

  // Address width never drops below one bit, even for tiny files
  function automatic int addr_w(input int l);
    return (l <= 2) ? 1 : $clog2(l);
  endfunction

  typedef logic [addr_w(L_DEF)-1:0] reg_addr_t;

  typedef struct packed {
    logic rd1;
    logic rd2;
    logic waw;
  } hazard_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write reservations, occupancy count and hazard detection
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int  L      = L_DEF,
  parameter int  BYPASS = 1,
  localparam int AW     = addr_w(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic          iss,
  input  logic [AW-1:0] iss_wa,
  input  logic          flush,
  output logic          stall,
  output logic [AW:0]   pend_cnt
);

  localparam bit BP = (BYPASS != 0);

  logic [L-1:0] r_pend;
  logic [AW:0]  r_cnt;
  logic [L-1:0] w_pend_nxt;
  logic [AW:0]  w_cnt_nxt;
  logic         w_wr;
  logic         w_iss_ok;
  logic         w_stall;
  hazard_t      w_haz;

  always_comb begin
    w_wr      = we3 && (wa3 != '0);
    // A pending source is harmless only when its write is forwarded this cycle
    w_haz.rd1 = (ra1 != '0) && r_pend[ra1] && !(BP && w_wr && (wa3 == ra1));
    w_haz.rd2 = (ra2 != '0) && r_pend[ra2] && !(BP && w_wr && (wa3 == ra2));
    w_haz.waw = iss && (iss_wa != '0) && r_pend[iss_wa] && !(w_wr && (wa3 == iss_wa));
    w_stall   = rst_n && (|w_haz);
    w_iss_ok  = iss && (iss_wa != '0) && !w_stall;
  end

  // Priority: flush over issue-set over writeback-clear
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr) w_pend_nxt[wa3] = 1'b0;
    if (w_iss_ok) w_pend_nxt[iss_wa] = 1'b1;
    if (flush) w_pend_nxt = '0;
    w_pend_nxt[0] = 1'b0;
    w_cnt_nxt = (AW+1)'($countones(w_pend_nxt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign stall    = w_stall;
  assign pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-read one-write register file with write forwarding and a reservation scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  N      = N_DEF,
  parameter int  L      = L_DEF,
  parameter int  BYPASS = 1,
  localparam int AW     = addr_w(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [N-1:0]  wd3,
  input  logic          iss,
  input  logic [AW-1:0] iss_wa,
  input  logic          flush,
  output logic          stall,
  output logic [AW:0]   pend_cnt,
  input  logic [AW-1:0] checka,
  output logic [N-1:0]  check
);

  localparam bit BP = (BYPASS != 0);

  logic [N-1:0] r_rf [L];
  logic         w_wr_en;
  logic         w_fwd1;
  logic         w_fwd2;
  logic [N-1:0] w_rd1;
  logic [N-1:0] w_rd2;
  logic [N-1:0] w_check;

  assign w_wr_en = we3 && (wa3 != '0);
  assign w_fwd1  = BP && w_wr_en && (wa3 == ra1);
  assign w_fwd2  = BP && w_wr_en && (wa3 == ra2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) r_rf[i] <= '0;
    end else if (w_wr_en) begin
      r_rf[wa3] <= wd3;
    end
  end

  // Reads are forced to zero during reset so a live writeback cannot leak through
  always_comb begin
    w_rd1   = '0;
    w_rd2   = '0;
    w_check = '0;
    if (rst_n) begin
      if (w_fwd1) w_rd1 = wd3;
      else if (ra1 != '0) w_rd1 = r_rf[ra1];
      if (w_fwd2) w_rd2 = wd3;
      else if (ra2 != '0) w_rd2 = r_rf[ra2];
      if (checka != '0) w_check = r_rf[checka];
    end
  end

  assign rd1   = w_rd1;
  assign rd2   = w_rd2;
  assign check = w_check;

  rf_scoreboard #(
    .L      (L),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .we3      (we3),
    .wa3      (wa3),
    .iss      (iss),
    .iss_wa   (iss_wa),
    .flush    (flush),
    .stall    (stall),
    .pend_cnt (pend_cnt)
  );

endmodule
